// File: rtl/counter_pkg.sv
// Constants shared by the up- and down-counter blocks of the timer family.
`timescale 1ns/100ps
package counter_pkg;
  localparam int CNT_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
endpackage

// File: rtl/down_counter_4bit.sv
// Loadable down-counter with zero flag and registered terminal-count pulse.
// Define DOWN_COUNTER_RELOAD_EN to add the reload register and auto-reload/one-shot modes.
`timescale 1ns/100ps
module down_counter_4bit
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             auto,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             tc
);

  logic [WIDTH-1:0] q_next;
  logic             tc_next;

`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_next;
`else
  // The mode input only matters when the reload register exists.
  logic unused_auto;
  assign unused_auto = auto;
`endif

  assign zero = (q == '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q  <= '0;
      tc <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      q  <= q_next;
      tc <= tc_next;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload <= reload_next;
`endif
    end
  end

  // Load beats enable; at zero the counter either wraps, reloads or parks.
  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
    reload_next = reload;
`endif
    if (ld) begin
      q_next = d;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_next = d;
`endif
    end else if (en) begin
      if (q != '0) begin
        q_next  = q - WIDTH'(1);
        tc_next = (q == WIDTH'(1));
      end else begin
`ifdef DOWN_COUNTER_RELOAD_EN
        q_next = auto ? reload : q;
`else
        q_next = '1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_down_counter_4bit.sv
// Directed bench for down_counter_4bit: arithmetic reference model checked every cycle
// plus literal expectations at each step.
`timescale 1ns/100ps
module tb_down_counter_4bit;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] d = 4'h0;
  logic       en = 1'b0;
  logic       auto = 1'b0;
  logic [3:0] q;
  logic       zero;
  logic       tc;

  int errors = 0;
  int checks = 0;

  int mq = 0;
  int mreload = 0;
  bit mtc = 1'b0;

  down_counter_4bit dut (
    .clk (clk),
    .clr (clr),
    .ld  (ld),
    .d   (d),
    .en  (en),
    .auto(auto),
    .q   (q),
    .zero(zero),
    .tc  (tc)
  );

  always #1 clk = ~clk;

  // Reference model: integer count modulo 16, pulse when a decrement lands on zero.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mq      <= 0;
      mtc     <= 1'b0;
      mreload <= 0;
    end else if (ld) begin
      mq      <= int'(d);
      mreload <= int'(d);
      mtc     <= 1'b0;
    end else if (en && mq > 0) begin
      mq  <= mq - 1;
      mtc <= (mq - 1 == 0);
    end else if (en) begin
`ifdef DOWN_COUNTER_RELOAD_EN
      mq  <= auto ? mreload : 0;
`else
      mq  <= 15;
`endif
      mtc <= 1'b0;
    end else begin
      mtc <= 1'b0;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (q !== mq[3:0] || tc !== mtc || zero !== (mq == 0)) begin
      errors++;
      $display("[TB] FAIL model t=%0t got q=%h tc=%b zero=%b want q=%h tc=%b zero=%b",
               $time, q, tc, zero, mq[3:0], mtc, (mq == 0));
    end
  end

  task automatic applyStimulus(input logic l, input logic [3:0] dv, input logic e, input logic a);
    ld   = l;
    d    = dv;
    en   = e;
    auto = a;
    @(posedge clk);
    #0.5;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eq, input logic etc);
    checks++;
    if (q !== eq || tc !== etc || zero !== (eq == 4'h0)) begin
      errors++;
      $display("[TB] FAIL %s got q=%h tc=%b zero=%b want q=%h tc=%b zero=%b",
               name, q, tc, zero, eq, etc, (eq == 4'h0));
    end
  endtask

  task automatic pulseClr(input string name);
    clr = 1'b1;
    #0.3;
    checkOutput(name, 4'h0, 1'b0);
    #0.7;
    clr = 1'b0;
  endtask

  initial begin
    #0.1;
    clr = 1'b1;
    #0.4;
    checkOutput("reset_async", 4'h0, 1'b0);
    clr = 1'b0;
    applyStimulus(0, 4'h0, 0, 0); checkOutput("hold_after_reset0", 4'h0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0); checkOutput("hold_after_reset1", 4'h0, 1'b0);

    applyStimulus(1, 4'h9, 0, 0); checkOutput("load9", 4'h9, 1'b0);
    pulseClr("clr_from9");

    applyStimulus(1, 4'h3, 0, 0); checkOutput("load3", 4'h3, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("count2", 4'h2, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("count1", 4'h1, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("count0_tc", 4'h0, 1'b1);
`ifndef DOWN_COUNTER_RELOAD_EN
    applyStimulus(0, 4'h0, 1, 0); checkOutput("wrapF", 4'hF, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("wrapE", 4'hE, 1'b0);
`else
    applyStimulus(1, 4'h2, 0, 0); checkOutput("os_load2", 4'h2, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("os_1", 4'h1, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("os_0_tc", 4'h0, 1'b1);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("os_park0", 4'h0, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("os_park1", 4'h0, 1'b0);

    applyStimulus(1, 4'h2, 0, 1); checkOutput("ar_load2", 4'h2, 1'b0);
    applyStimulus(0, 4'h0, 1, 1); checkOutput("ar_1a", 4'h1, 1'b0);
    applyStimulus(0, 4'h0, 1, 1); checkOutput("ar_0a_tc", 4'h0, 1'b1);
    applyStimulus(0, 4'h0, 1, 1); checkOutput("ar_2b", 4'h2, 1'b0);
    applyStimulus(0, 4'h0, 1, 1); checkOutput("ar_1b", 4'h1, 1'b0);
    applyStimulus(0, 4'h0, 1, 1); checkOutput("ar_0b_tc", 4'h0, 1'b1);
    applyStimulus(0, 4'h0, 1, 1); checkOutput("ar_2c", 4'h2, 1'b0);
    applyStimulus(0, 4'h0, 1, 1); checkOutput("ar_1c", 4'h1, 1'b0);

    applyStimulus(1, 4'h0, 0, 1); checkOutput("ar_load0", 4'h0, 1'b0);
    applyStimulus(0, 4'h0, 1, 1); checkOutput("ar_reload0", 4'h0, 1'b0);
`endif

    applyStimulus(1, 4'h6, 0, 0); checkOutput("load6", 4'h6, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("count5", 4'h5, 1'b0);
    applyStimulus(1, 4'hA, 1, 0); checkOutput("ld_beats_en", 4'hA, 1'b0);
    applyStimulus(0, 4'h0, 0, 0); checkOutput("holdA", 4'hA, 1'b0);
    applyStimulus(1, 4'h8, 0, 0); checkOutput("load8", 4'h8, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("count7", 4'h7, 1'b0);
    pulseClr("clr_from7");
    applyStimulus(0, 4'h0, 0, 0); checkOutput("after_clr", 4'h0, 1'b0);

    applyStimulus(1, 4'h0, 1, 0); checkOutput("load0_no_tc", 4'h0, 1'b0);
    applyStimulus(1, 4'h1, 0, 0); checkOutput("load1", 4'h1, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("1to0_tc", 4'h0, 1'b1);
    applyStimulus(0, 4'h0, 0, 0); checkOutput("tc_one_cycle", 4'h0, 1'b0);
    applyStimulus(1, 4'hF, 0, 0); checkOutput("loadF", 4'hF, 1'b0);
    applyStimulus(0, 4'h0, 1, 0); checkOutput("countE", 4'hE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
